// File: rtl/parallel_adder_pkg.sv
// Shared helpers for the pipelined reduction adder: width derivation,
// tree-shape arithmetic and sign/zero extension.
// Build option: PARALLEL_ADDER_ACCUM_EN enables cross-vector accumulation.
package parallel_adder_pkg;

    // Widest value the extend helper can produce; callers truncate to their width.
    localparam int EXT_MAX = 128;

`ifdef PARALLEL_ADDER_ACCUM_EN
    localparam bit ACCUM_EN = 1'b1;
`else
    localparam bit ACCUM_EN = 1'b0;
`endif

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Tree result width: enough headroom that DIM adds can never overflow.
    function automatic int res_w(input int w, input int dim);
        return w + clog2(dim);
    endfunction

    function automatic int acc_w(input int w, input int dim, input int extra);
        return res_w(w, dim) + extra;
    endfunction

    // Width of the sum port for the current build.
    function automatic int sum_w(input int w, input int dim, input int extra);
        return ACCUM_EN ? acc_w(w, dim, extra) : res_w(w, dim);
    endfunction

    // Register stages in the tree; a single element still gets one stage.
    function automatic int levels(input int dim);
        return (clog2(dim) < 1) ? 1 : clog2(dim);
    endfunction

    // Number of terms left after k pairing levels (odd leftovers carried).
    function automatic int terms_at(input int dim, input int k);
        return (dim + (1 << k) - 1) >> k;
    endfunction

    // Extend the low w bits of x to EXT_MAX bits, sign- or zero-filling.
    function automatic logic [EXT_MAX-1:0] extend(input logic [EXT_MAX-1:0] x,
                                                  input int w, input bit sgn);
        logic [EXT_MAX-1:0] r;
        for (int i = 0; i < EXT_MAX; i++)
            r[i] = (i < w) ? x[i] : (sgn & x[w-1]);
        return r;
    endfunction

endpackage

// File: rtl/adder_tree_stage.sv
// One level of the reduction tree: adds adjacent term pairs, passes an odd
// leftover term through, and registers the result with its valid bit.
module adder_tree_stage #(
    parameter int N_IN = 2,
    parameter int TW   = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            en,
    input  logic                            valid_i,
    input  logic [N_IN-1:0][TW-1:0]         terms_i,
    output logic                            valid_o,
    output logic [(N_IN+1)/2-1:0][TW-1:0]   terms_o
);
    localparam int N_OUT = (N_IN + 1) / 2;

    logic [N_OUT-1:0][TW-1:0] pair_sum;
    logic [N_OUT-1:0][TW-1:0] terms_d, terms_q;
    logic                     valid_d, valid_q;

    for (genvar j = 0; j < N_OUT; j++) begin : pair_g
        if (2 * j + 1 < N_IN) begin : g_add
            assign pair_sum[j] = terms_i[2*j] + terms_i[2*j+1];
        end else begin : g_pass
            assign pair_sum[j] = terms_i[2*j];
        end
    end

    // Load the new level when the pipeline advances, otherwise hold.
    always_comb begin
        terms_d = terms_q;
        valid_d = valid_q;
        if (en) begin
            terms_d = pair_sum;
            valid_d = valid_i;
        end
    end

    // Stage register; reset drops the in-flight term and its valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            terms_q <= '0;
            valid_q <= 1'b0;
        end else begin
            terms_q <= terms_d;
            valid_q <= valid_d;
        end
    end

    assign terms_o = terms_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/pipelined_reduction_adder.sv
// Pipelined adder-tree reduction of a DIM-element vector to one sum, with a
// global stall (adv) shared by every stage so backpressure never loses data.
// Build option: PARALLEL_ADDER_ACCUM_EN adds in_last and an accumulator that
// sums tree results across a group and reports only the group total.
module pipelined_reduction_adder
    import parallel_adder_pkg::*;
#(
    parameter int DIM       = 8,
    parameter int W         = 16,
    parameter bit SIGNED    = 1'b0,
    parameter int ACC_EXTRA = 8
) (
    input  logic                                  Clock,
    input  logic                                  Reset,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [DIM*W-1:0]                      vector,
`ifdef PARALLEL_ADDER_ACCUM_EN
    input  logic                                  in_last,
`endif
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [sum_w(W, DIM, ACC_EXTRA)-1:0]   sum
);
    localparam int RES_W = res_w(W, DIM);
    localparam int SUM_W = sum_w(W, DIM, ACC_EXTRA);
    localparam int L     = levels(DIM);

    logic                      adv;
    logic [DIM-1:0][RES_W-1:0] ext_terms;
    logic [RES_W-1:0]          tree_sum;
    logic                      tree_vld;

    // Everything moves together; the only stall source is an unaccepted output.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Widen every element to the result width before the first add.
    always_comb begin
        for (int i = 0; i < DIM; i++)
            ext_terms[i] = RES_W'(extend(EXT_MAX'(vector[W*i +: W]), W, SIGNED));
    end

    for (genvar k = 0; k < L; k++) begin : lvl_g
        localparam int N_IN  = terms_at(DIM, k);
        localparam int N_OUT = terms_at(DIM, k + 1);
        logic [N_IN-1:0][RES_W-1:0]  t_in;
        logic                        v_in;
        logic [N_OUT-1:0][RES_W-1:0] t_out;
        logic                        v_out;

        if (k == 0) begin : g_first
            assign t_in = ext_terms;
            assign v_in = in_valid;
        end else begin : g_next
            assign t_in = lvl_g[k-1].t_out;
            assign v_in = lvl_g[k-1].v_out;
        end

        adder_tree_stage #(.N_IN(N_IN), .TW(RES_W)) u_stage (
            .clk     (Clock),
            .rst     (Reset),
            .en      (adv),
            .valid_i (v_in),
            .terms_i (t_in),
            .valid_o (v_out),
            .terms_o (t_out)
        );
    end

    assign tree_sum = lvl_g[L-1].t_out[0];
    assign tree_vld = lvl_g[L-1].v_out;

`ifdef PARALLEL_ADDER_ACCUM_EN
    logic [L-1:0]     last_d, last_q;
    logic [SUM_W-1:0] acc_d, acc_q, tree_ext;
    logic             mid_d, mid_q;
    logic             ov_d, ov_q;

    assign tree_ext = SUM_W'(extend(EXT_MAX'(tree_sum), RES_W, SIGNED));

    // in_last travels alongside its vector through the tree levels.
    always_comb begin
        last_d = last_q;
        if (adv) begin
            last_d[0] = in_last;
            for (int i = 1; i < L; i++) last_d[i] = last_q[i-1];
        end
    end

    // First result of a group loads, later ones add; only the last one is shown.
    always_comb begin
        acc_d = acc_q;
        mid_d = mid_q;
        ov_d  = ov_q;
        if (adv) begin
            ov_d = tree_vld && last_q[L-1];
            if (tree_vld) begin
                acc_d = mid_q ? acc_q + tree_ext : tree_ext;
                mid_d = !last_q[L-1];
            end
        end
    end

    // Accumulator stage registers; reset abandons any partial group.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            last_q <= '0;
            acc_q  <= '0;
            mid_q  <= 1'b0;
            ov_q   <= 1'b0;
        end else begin
            last_q <= last_d;
            acc_q  <= acc_d;
            mid_q  <= mid_d;
            ov_q   <= ov_d;
        end
    end

    assign sum       = acc_q;
    assign out_valid = ov_q;
`else
    assign sum       = tree_sum;
    assign out_valid = tree_vld;
`endif

endmodule
